// File: rtl/shift4_serializer_ctrl.sv
// shift4_serializer_ctrl
// Control FSM that serializes 4-bit words LSB first by driving an external
// 4-bit right-shift register (load / shift strobes) and presenting its bit 0
// on a valid/ready serial output. An optional idle gap of GAP cycles follows
// the last bit of every word. A count of completed words is kept.
module shift4_serializer_ctrl #(
    parameter int GAP = 0
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last,
    output logic       sr_load,
    output logic       sr_ena,
    output logic [3:0] sr_data,
    input  logic [3:0] sr_q,
    output logic       busy,
    output logic [7:0] words_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Value loaded into the gap counter after a word's last bit; the gap
    // state then lasts gcnt+1 cycles, i.e. exactly GAP cycles.
    localparam int         GAP_M1   = (GAP > 0) ? (GAP - 1) : 0;
    localparam logic [3:0] GAP_LOAD = GAP_M1[3:0];
    localparam logic       HAS_GAP  = (GAP > 0) ? 1'b1 : 1'b0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_bcnt;
    logic [1:0]  w_bcnt_nxt;
    logic [3:0]  r_gcnt;
    logic [3:0]  w_gcnt_nxt;
    logic [7:0]  r_words_done;
    logic [7:0]  w_words_done_nxt;

    // Ungated per-state output values, before reset masking
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_out_bit;
    logic        w_out_last;
    logic        w_sr_load;
    logic        w_sr_ena;
    logic [3:0]  w_sr_data;
    logic        w_busy;

    // Only bit 0 of the external register is the serial output; the upper
    // bits are observed but carry no control meaning.
    logic        w_unused_sr_q;
    assign w_unused_sr_q = ^sr_q[3:1];

    // State, counters and completed-word count; synchronous reset has priority
    always_ff @(posedge clk) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_bcnt       <= 2'd0;
            r_gcnt       <= 4'd0;
            r_words_done <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_gcnt       <= w_gcnt_nxt;
            r_words_done <= w_words_done_nxt;
        end
    end

    // Next-state logic and per-state outputs; everything holds unless a
    // transition below says otherwise
    always_comb begin
        w_state_nxt      = r_state;
        w_bcnt_nxt       = r_bcnt;
        w_gcnt_nxt       = r_gcnt;
        w_words_done_nxt = r_words_done;
        w_in_ready       = 1'b0;
        w_out_valid      = 1'b0;
        w_out_bit        = 1'b0;
        w_out_last       = 1'b0;
        w_sr_load        = 1'b0;
        w_sr_ena         = 1'b0;
        w_sr_data        = 4'd0;
        w_busy           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                w_sr_load  = in_valid;
                w_sr_data  = in_data;
                if (in_valid) begin
                    // The register holds the word from the next cycle on
                    w_state_nxt = ST_SHIFT;
                    w_bcnt_nxt  = 2'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                w_out_bit   = sr_q[0];
                w_out_last  = (r_bcnt == 2'd3);
                if (out_ready) begin
                    w_sr_ena   = 1'b1;
                    w_bcnt_nxt = r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) begin
                        w_words_done_nxt = r_words_done + 8'd1;
                        if (HAS_GAP) begin
                            w_state_nxt = ST_GAP;
                            w_gcnt_nxt  = GAP_LOAD;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    // Downstream stalled: present the same bit again
                    w_state_nxt = ST_SHIFT;
                end
            end

            ST_GAP: begin
                w_busy = 1'b1;
                if (r_gcnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gcnt_nxt = r_gcnt - 4'd1;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle state
                w_state_nxt = ST_IDLE;
                w_bcnt_nxt  = 2'd0;
                w_gcnt_nxt  = 4'd0;
            end
        endcase
    end

    // Mask every strobe and handshake while reset is asserted
    always_comb begin
        if (areset) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_bit   = 1'b0;
            out_last  = 1'b0;
            sr_load   = 1'b0;
            sr_ena    = 1'b0;
            sr_data   = 4'd0;
            busy      = 1'b0;
        end else begin
            in_ready  = w_in_ready;
            out_valid = w_out_valid;
            out_bit   = w_out_bit;
            out_last  = w_out_last;
            sr_load   = w_sr_load;
            sr_ena    = w_sr_ena;
            sr_data   = w_sr_data;
            busy      = w_busy;
        end
    end

    assign words_done = r_words_done;

endmodule

// File: tb/tb_shift4_serializer_ctrl.sv
// Testbench for shift4_serializer_ctrl: two instances (GAP=0 and GAP=3),
// each with a behavioural external shift register. Accepted words push their
// expected bit sequence into a scoreboard queue; a negedge monitor pops and
// compares on every accepted serial beat and checks the handshake rules.
module tb_shift4_serializer_ctrl;

    logic       clk;
    logic       areset;
    logic       iv    [2];
    logic [3:0] id    [2];
    logic       ordy  [2];
    logic       ir    [2];
    logic       ov    [2];
    logic       ob    [2];
    logic       ol    [2];
    logic       sl    [2];
    logic       se    [2];
    logic [3:0] sd    [2];
    logic [3:0] sq    [2];
    logic       bz    [2];
    logic [7:0] wd    [2];

    int checks = 0;
    int errors = 0;

    // scoreboard entries: {bit, last}
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    int bp_mode [2];   // 0: always ready, 1: random, 2: driven by the sequence

    initial clk = 1'b0;
    always #5 clk = ~clk;

    shift4_serializer_ctrl #(.GAP(0)) u_dut_g0 (
        .clk(clk), .areset(areset),
        .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
        .out_ready(ordy[0]), .out_valid(ov[0]), .out_bit(ob[0]), .out_last(ol[0]),
        .sr_load(sl[0]), .sr_ena(se[0]), .sr_data(sd[0]), .sr_q(sq[0]),
        .busy(bz[0]), .words_done(wd[0])
    );

    shift4_serializer_ctrl #(.GAP(3)) u_dut_g3 (
        .clk(clk), .areset(areset),
        .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
        .out_ready(ordy[1]), .out_valid(ov[1]), .out_bit(ob[1]), .out_last(ol[1]),
        .sr_load(sl[1]), .sr_ena(se[1]), .sr_data(sd[1]), .sr_q(sq[1]),
        .busy(bz[1]), .words_done(wd[1])
    );

    // External 4-bit right-shift registers, zero-fill on shift
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sl[k])      sq[k] <= sd[k];
            else if (se[k]) sq[k] <= {1'b0, sq[k][3:1]};
        end
    end

    function automatic int gap_of(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0h required=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic push_word(int k, logic [3:0] d);
        for (int i = 0; i < 4; i++) begin
            if (k == 0) q0.push_back({d[i], (i == 3) ? 1'b1 : 1'b0});
            else        q1.push_back({d[i], (i == 3) ? 1'b1 : 1'b0});
        end
    endtask

    // Present a word and hold it until accepted; returns at posedge+1 after acceptance
    task automatic send(int k, logic [3:0] d);
        bit acc;
        acc = 1'b0;
        iv[k] = 1'b1;
        id[k] = d;
        for (int n = 0; n < 400 && !acc; n++) begin
            @(negedge clk);
            if (ir[k]) begin
                acc = 1'b1;
                push_word(k, d);
            end
            @(posedge clk);
            #1;
        end
        iv[k] = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst%0d actual=not_accepted required=accepted", k);
        end
    endtask

    // Wait until the instance is idle with nothing left to deliver
    task automatic wait_drain(int k);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (ir[k] && qsize(k) == 0) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout inst%0d actual=pending=%0d required=0", k, qsize(k));
        end
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                case (bp_mode[k])
                    0:       ordy[k] = 1'b1;
                    1:       ordy[k] = ($urandom_range(0, 3) != 0);
                    default: ordy[k] = ordy[k];
                endcase
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [7:0] model_wd [2];
        bit         gap_trk  [2];
        int         gap_cnt  [2];
        bit         acc_prev [2];
        bit         hold_prev[2];
        logic       hb       [2];
        logic       hl       [2];
        bit         post_rst [2];
        logic [1:0] e;
        for (int k = 0; k < 2; k++) begin
            model_wd[k] = 8'd0; gap_trk[k] = 1'b0; gap_cnt[k] = 0;
            acc_prev[k] = 1'b0; hold_prev[k] = 1'b0; post_rst[k] = 1'b0;
            hb[k] = 1'b0; hl[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (areset) begin
                    chk("reset_outputs", k,
                        {25'd0, ir[k], ov[k], ol[k], sl[k], se[k], bz[k], (sd[k] != 4'd0)}, 32'd0);
                    if (k == 0) q0.delete(); else q1.delete();
                    model_wd[k] = 8'd0; gap_trk[k] = 1'b0; acc_prev[k] = 1'b0;
                    hold_prev[k] = 1'b0; post_rst[k] = 1'b1;
                end else begin
                    if (post_rst[k]) begin
                        chk("post_reset_ready", k, ir[k], 1);
                        post_rst[k] = 1'b0;
                    end
                    chk("words_done", k, wd[k], model_wd[k]);
                    chk("load_ena_excl", k, sl[k] & se[k], 0);
                    chk("sr_ena_rule", k, se[k], ov[k] & ordy[k]);
                    chk("sr_load_rule", k, sl[k], ir[k] & iv[k]);
                    chk("busy_rule", k, bz[k], !ir[k]);
                    chk("ready_valid_excl", k, ir[k] & ov[k], 0);
                    chk("sr_data_rule", k, sd[k], ir[k] ? id[k] : 4'd0);
                    if (acc_prev[k]) chk("valid_after_accept", k, ov[k], 1);
                    acc_prev[k] = iv[k] & ir[k];
                    if (hold_prev[k]) chk("hold_bit", k, {ov[k], ob[k], ol[k]}, {1'b1, hb[k], hl[k]});
                    hold_prev[k] = ov[k] & !ordy[k];
                    hb[k] = ob[k];
                    hl[k] = ol[k];
                    if (gap_trk[k]) begin
                        if (ir[k]) begin
                            chk("gap_len", k, gap_cnt[k], gap_of(k));
                            gap_trk[k] = 1'b0;
                        end else begin
                            chk("gap_quiet", k, ov[k] | sl[k] | se[k], 0);
                            gap_cnt[k]++;
                        end
                    end
                    if (ov[k] && ordy[k]) begin
                        if (qsize(k) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat inst%0d actual=bit%0d required=no_beat", k, ob[k]);
                        end else begin
                            e = (k == 0) ? q0.pop_front() : q1.pop_front();
                            chk("out_bit", k, ob[k], e[1]);
                            chk("out_last", k, ol[k], e[0]);
                            if (e[0]) begin
                                model_wd[k] = model_wd[k] + 8'd1;
                                gap_trk[k] = 1'b1;
                                gap_cnt[k] = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Stimulus sequence
    initial begin
        areset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; id[k] = 4'd0; ordy[k] = 1'b1; bp_mode[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;

        // Single word, no gap
        send(0, 4'b1011);
        wait_drain(0);
        chk("single_word_done", 0, wd[0], 1);

        // Backpressure for 3 cycles after the 2nd bit
        bp_mode[0] = 2;
        ordy[0] = 1'b1;
        send(0, 4'b0110);
        repeat (2) begin @(posedge clk); #1; end
        ordy[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        wait_drain(0);
        chk("backpressure_done", 0, wd[0], 2);
        bp_mode[0] = 0;

        // Reset on the 3rd shift beat
        send(0, 4'h9);
        repeat (2) begin @(posedge clk); #1; end
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        chk("reset_midword_done", 0, wd[0], 0);
        wait_drain(0);

        // GAP=3, back-to-back words
        send(1, 4'h5);
        send(1, 4'hA);
        wait_drain(1);
        chk("gap_pair_done", 1, wd[1], 2);

        // Random traffic with random backpressure on the gap instance
        bp_mode[1] = 1;
        for (int n = 0; n < 30; n++) send(1, 4'($urandom_range(0, 15)));
        wait_drain(1);
        bp_mode[1] = 0;
        chk("gap_random_done", 1, wd[1], 32);

        // 256 words: counter wraps to zero
        bp_mode[0] = 1;
        for (int n = 0; n < 256; n++) send(0, 4'($urandom_range(0, 15)));
        wait_drain(0);
        bp_mode[0] = 0;
        chk("wrap_words_done", 0, wd[0], 0);

        chk("queue0_empty", 0, q0.size(), 0);
        chk("queue1_empty", 1, q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
